wb_data_select: RTL

WB_DATA_SELECT -- requirements
Module: wb_data_select

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_data_select_if.sv | 29 ++
 rtl/wb_skid_buf.sv | 85 ++++++++
 rtl/wb_data_select.sv | 55 +++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and skid-buffer state encoding for the writeback data select path.
package wb_pkg;

  localparam int DATA_W    = 32;
  localparam int N_SRC     = 9;
  localparam int SEL_W     = 4;
  localparam int CONST_IDX = 5;
  localparam int CONST_VAL = 227;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_data_select_if.sv
// Writeback select bus: upstream offer, downstream writeback word and bad-select count.
interface wb_data_select_if #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int N_SRC  = wb_pkg::N_SRC,
  parameter int SEL_W  = wb_pkg::SEL_W
);

  logic [N_SRC*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              bad_sel_cnt;

  modport master (
    output in_data, select, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, bad_sel_cnt
  );

  modport slave (
    input  in_data, select, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, bad_sel_cnt
  );

endinterface

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; out_payload is always the oldest entry.
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | head holds the only entry
//   TWO   | head is oldest, skid holds the newer entry, in_ready low
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int WIDTH = wb_pkg::DATA_W + wb_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  input  logic             out_ready
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, skid;
  logic             accept, drain;
  logic             load_head, load_skid, promote;

  assign out_valid   = (state != EMPTY);
  assign out_payload = head;
  assign accept      = in_valid & in_ready;
  assign drain       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          case ({accept, drain})
            2'b10: begin
              state_nxt = TWO;
              load_skid = 1'b1;
            end
            2'b01:   state_nxt = EMPTY;
            2'b11:   load_head = 1'b1;
            default: state_nxt = ONE;
          endcase
        end
        TWO: begin
          if (drain) begin
            state_nxt = ONE;
            promote   = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it is low exactly in TWO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (load_head) head <= in_payload;
      else if (promote) head <= skid;
      if (load_skid) skid <= in_payload;
    end
  end

endmodule

// File: rtl/wb_data_select.sv
// Writeback source decode feeding a 2-entry skid buffer, plus a saturating bad-select counter.
module wb_data_select #(
  parameter int DATA_W    = wb_pkg::DATA_W,
  parameter int N_SRC     = wb_pkg::N_SRC,
  parameter int SEL_W     = wb_pkg::SEL_W,
  parameter int CONST_IDX = wb_pkg::CONST_IDX,
  parameter int CONST_VAL = wb_pkg::CONST_VAL
) (
  input  logic               clk,
  input  logic               reset,
  wb_data_select_if.slave    bus
);

  logic [DATA_W-1:0] word;
  logic              is_bad;
  logic              accept;

  always_comb begin
    word   = '0;
    is_bad = (32'(bus.select) >= 32'(N_SRC));
    if (bus.select == SEL_W'(CONST_IDX)) begin
      word = DATA_W'(CONST_VAL);
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        if (bus.select == SEL_W'(k)) word = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // a flushed accept is discarded, so it must not count either
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bad_sel_cnt <= 8'd0;
    end else if (accept && is_bad && (bus.bad_sel_cnt != 8'hFF)) begin
      bus.bad_sel_cnt <= bus.bad_sel_cnt + 8'd1;
    end
  end

  wb_skid_buf #(
    .WIDTH(DATA_W + SEL_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_payload ({bus.select, word}),
    .out_valid  (bus.out_valid),
    .out_payload({bus.out_sel, bus.out_data}),
    .out_ready  (bus.out_ready)
  );

endmodule
